// File: rtl/ram_mult_sequencer_if.sv
// s2-port bus between the multiply sequencer (master) and the shared RAM (slave).
interface ram_mult_sequencer_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 2
);
   logic [ADDR_W-1:0]   ram_address;
   logic                ram_chipselect;
   logic                ram_clken;
   logic                ram_write;
   logic [DATA_W-1:0]   ram_writedata;
   logic [DATA_W/8-1:0] ram_byteenable;
   logic [DATA_W-1:0]   ram_readdata;

   modport master (
      output ram_address, ram_chipselect, ram_clken,
      output ram_write, ram_writedata, ram_byteenable,
      input  ram_readdata
   );

   modport slave (
      input  ram_address, ram_chipselect, ram_clken,
      input  ram_write, ram_writedata, ram_byteenable,
      output ram_readdata
   );
endinterface

// File: rtl/ram_mult_sequencer.sv
// Polls CTRL in shared RAM, runs a shift-add multiply on words 0/1, posts word 3 and CTRL.
// Define RAM_MULT_SIGNED_EN for two's-complement operands and a sign-extended product.
module ram_mult_sequencer #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 2,
   parameter int OP_W     = 16,
   parameter int READ_LAT = 1,
   parameter int POLL_GAP = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   ram_mult_sequencer_if.master ram,
   output logic busy,
   output logic done_pulse
);

   typedef enum logic [3:0] {
      IDLE, POLL, PWAIT, MARK, RDA, AWAIT,
      RDB, BWAIT, MUL, WRES, WCTL, GAP
   } state_t;

   localparam logic [ADDR_W-1:0] A_OPA  = ADDR_W'(0);
   localparam logic [ADDR_W-1:0] A_OPB  = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] A_CTRL = ADDR_W'(2);
   localparam logic [ADDR_W-1:0] A_RES  = ADDR_W'(3);

   state_t state, state_nx, after_op;

   logic [15:0]       cnt;
   logic [7:0]        seq;
   logic [7:0]        seq_inc;
   logic              clken_q;
   logic [OP_W-1:0]   op_a;
   logic [OP_W-1:0]   mplier;
   logic [2*OP_W-1:0] mcand;
   logic [2*OP_W-1:0] acc;
   logic [OP_W-1:0]   rd_op;
   logic [DATA_W-1:0] result;
   logic              last_rd, last_mul, last_gap;
   logic              unused_rd;

   assign rd_op     = ram.ram_readdata[OP_W-1:0];
   assign unused_rd = ^ram.ram_readdata[DATA_W-1:OP_W];
   assign seq_inc   = seq + 8'd1;
   assign last_rd   = cnt == 16'(READ_LAT - 1);
   assign last_mul  = cnt == 16'(OP_W - 1);
   assign last_gap  = cnt == 16'(POLL_GAP - 1);
   assign after_op  = (POLL_GAP == 0) ? IDLE : GAP;

   function automatic logic [OP_W-1:0] mag(input logic [OP_W-1:0] v);
`ifdef RAM_MULT_SIGNED_EN
      return v[OP_W-1] ? -v : v;
`else
      return v;
`endif
   endfunction

`ifdef RAM_MULT_SIGNED_EN
   logic              a_neg;
   logic              neg;
   logic [2*OP_W-1:0] prod;

   assign prod   = neg ? -acc : acc;
   assign result = DATA_W'($signed(prod));
`else
   assign result = DATA_W'(acc);
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:  if (enable) state_nx = POLL;
         POLL:  state_nx = PWAIT;
         PWAIT: if (last_rd) begin
            state_nx = ram.ram_readdata[0] ? MARK : after_op;
         end
         MARK:  state_nx = RDA;
         RDA:   state_nx = AWAIT;
         AWAIT: if (last_rd) state_nx = RDB;
         RDB:   state_nx = BWAIT;
         BWAIT: if (last_rd) state_nx = MUL;
         MUL:   if (last_mul) state_nx = WRES;
         WRES:  state_nx = WCTL;
         WCTL:  state_nx = after_op;
         GAP:   if (last_gap) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // One multiplier bit per MUL cycle, LSB first.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt     <= '0;
         seq     <= '0;
         clken_q <= 1'b0;
         op_a    <= '0;
         mplier  <= '0;
         mcand   <= '0;
         acc     <= '0;
`ifdef RAM_MULT_SIGNED_EN
         a_neg   <= 1'b0;
         neg     <= 1'b0;
`endif
      end else begin
         clken_q <= 1'b1;
         cnt     <= (state_nx != state) ? '0 : cnt + 16'd1;
         if (state == AWAIT && last_rd) begin
            op_a <= mag(rd_op);
`ifdef RAM_MULT_SIGNED_EN
            a_neg <= rd_op[OP_W-1];
`endif
         end
         if (state == BWAIT && last_rd) begin
            mcand  <= {{OP_W{1'b0}}, op_a};
            mplier <= mag(rd_op);
            acc    <= '0;
`ifdef RAM_MULT_SIGNED_EN
            neg    <= a_neg ^ rd_op[OP_W-1];
`endif
         end
         if (state == MUL) begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
         end
         if (state == WCTL) seq <= seq_inc;
      end
   end

   assign ram.ram_clken      = clken_q;
   assign ram.ram_byteenable = '1;

   always_comb begin
      ram.ram_chipselect = 1'b0;
      ram.ram_write      = 1'b0;
      ram.ram_address    = '0;
      ram.ram_writedata  = '0;
      busy               = 1'b0;
      done_pulse         = 1'b0;
      unique case (state)
         POLL: begin
            ram.ram_chipselect = 1'b1;
            ram.ram_address    = A_CTRL;
         end
         MARK: begin
            ram.ram_chipselect = 1'b1;
            ram.ram_write      = 1'b1;
            ram.ram_address    = A_CTRL;
            ram.ram_writedata  = DATA_W'({seq, 8'h02});
            busy               = 1'b1;
         end
         RDA: begin
            ram.ram_chipselect = 1'b1;
            ram.ram_address    = A_OPA;
            busy               = 1'b1;
         end
         RDB: begin
            ram.ram_chipselect = 1'b1;
            ram.ram_address    = A_OPB;
            busy               = 1'b1;
         end
         AWAIT, BWAIT, MUL: busy = 1'b1;
         WRES: begin
            ram.ram_chipselect = 1'b1;
            ram.ram_write      = 1'b1;
            ram.ram_address    = A_RES;
            ram.ram_writedata  = result;
            busy               = 1'b1;
         end
         WCTL: begin
            ram.ram_chipselect = 1'b1;
            ram.ram_write      = 1'b1;
            ram.ram_address    = A_CTRL;
            ram.ram_writedata  = DATA_W'({seq_inc, 8'h04});
            done_pulse         = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_ram_mult_sequencer.sv
// Random and directed multiply ops against a RAM model and an arithmetic reference.
module tb_ram_mult_sequencer;
   localparam int DATA_W  = 32;
   localparam int ADDR_W  = 2;
   localparam int OP_W    = 16;
   localparam int RL      = 1;
   localparam int PGAP    = 4;
   localparam int LAT     = 3 * RL + 5 + OP_W;
   localparam int SPACING = 1 + RL + PGAP + 1;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic enable = 1'b0;
   logic busy, done_pulse;

   ram_mult_sequencer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   ram_mult_sequencer #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .OP_W(OP_W),
      .READ_LAT(RL), .POLL_GAP(PGAP)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable),
      .ram(bus), .busy(busy), .done_pulse(done_pulse)
   );

   always #5 clk = ~clk;

   logic [31:0] mem [4] = '{default: 32'h0};
   logic [31:0] rpipe [RL] = '{default: 32'h0};
   assign bus.ram_readdata = rpipe[RL-1];

   logic        hps_req = 1'b0;
   logic [1:0]  hps_addr = '0;
   logic [31:0] hps_wd = '0;

   logic        s_cs = 1'b0, s_we = 1'b0;
   logic [1:0]  s_addr = '0;
   logic [31:0] s_wd = '0;

   int cyc, polls, other_rd, writes, busy_hi, spacing_bad, bus_bad;
   int last_poll, mark_t0, lat, done_cnt, mark_cnt, rdb_cnt;
   logic [31:0] mark_wd = '0;
   bit idle_mon, idle_seen, prev_rd;

   int errors, checks;
   logic [7:0] seq_m;

   // Bus observed mid-cycle; the RAM model acts on those samples at the next edge.
   always @(negedge clk) begin
      cyc    <= cyc + 1;
      s_cs   <= bus.ram_chipselect;
      s_we   <= bus.ram_write;
      s_addr <= bus.ram_address;
      s_wd   <= bus.ram_writedata;
      prev_rd <= bus.ram_chipselect && !bus.ram_write;
      if (!idle_mon) idle_seen <= 1'b0;
      if (bus.ram_chipselect) begin
         if (prev_rd && bus.ram_write) bus_bad <= bus_bad + 1;
         if (bus.ram_write) begin
            writes <= writes + 1;
            if (bus.ram_address == 2'd2 && bus.ram_writedata[1]) begin
               mark_cnt <= mark_cnt + 1;
               mark_t0  <= last_poll;
               mark_wd  <= bus.ram_writedata;
            end
         end else if (bus.ram_address == 2'd2) begin
            polls     <= polls + 1;
            last_poll <= cyc;
            if (idle_mon) begin
               if (idle_seen && (cyc - last_poll) != SPACING)
                  spacing_bad <= spacing_bad + 1;
               idle_seen <= 1'b1;
            end
         end else begin
            other_rd <= other_rd + 1;
            if (bus.ram_address == 2'd1) rdb_cnt <= rdb_cnt + 1;
         end
      end
      if (idle_mon && busy) busy_hi <= busy_hi + 1;
      if (done_pulse) begin
         done_cnt <= done_cnt + 1;
         lat      <= cyc - mark_t0;
      end
   end

   always @(posedge clk) begin
      for (int i = RL - 1; i > 0; i--) rpipe[i] <= rpipe[i-1];
      rpipe[0] <= (s_cs && !s_we) ? mem[s_addr] : 32'h0;
      if (hps_req) mem[hps_addr] <= hps_wd;
      if (s_cs && s_we) mem[s_addr] <= s_wd;
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_mul(input logic [31:0] a,
                                           input logic [31:0] b);
`ifdef RAM_MULT_SIGNED_EN
      int sa, sb;
      sa = $signed(a[15:0]);
      sb = $signed(b[15:0]);
      return 32'(sa * sb);
`else
      longint ua, ub;
      ua = longint'(a[15:0]);
      ub = longint'(b[15:0]);
      return 32'(ua * ub);
`endif
   endfunction

   task automatic hps_write(input logic [1:0] a, input logic [31:0] d);
      hps_addr = a;
      hps_wd   = d;
      hps_req  = 1'b1;
      @(negedge clk);
      hps_req  = 1'b0;
   endtask

   task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                         input bit drop_en);
      int d0, m0;
      bit ok;
      logic [31:0] exp;
      logic [7:0] prev;
      exp = ref_mul(a, b);
      d0 = done_cnt;
      m0 = mark_cnt;
      hps_write(2'd0, a);
      hps_write(2'd1, b);
      hps_write(2'd2, 32'h1);
      ok = 1'b0;
      for (int i = 0; i < 400 && !ok; i++) begin
         @(negedge clk);
         if (drop_en && mark_cnt != m0) enable = 1'b0;
         if (done_cnt != d0) ok = 1'b1;
      end
      check("op_done", 32'(ok), 32'h1);
      if (!ok) return;
      prev  = seq_m;
      seq_m = seq_m + 8'd1;
      check("result", mem[3], exp);
      check("ctrl", mem[2], {16'h0, seq_m, 8'h04});
      check("mark", mark_wd, {16'h0, prev, 8'h02});
      check("latency", 32'(lat), 32'(LAT));
      check("busy_after", 32'(busy), 32'h0);
   endtask

   initial begin
      int p0, w0, o0, r0;
      bit ok;
      logic [31:0] a, b;
      seq_m = 8'h0;
      #1 reset = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_cs", 32'(bus.ram_chipselect), 32'h0);
      check("rst_we", 32'(bus.ram_write), 32'h0);
      check("rst_addr", 32'(bus.ram_address), 32'h0);
      check("rst_wd", bus.ram_writedata, 32'h0);
      check("rst_be", 32'(bus.ram_byteenable), 32'hF);
      check("rst_clken", 32'(bus.ram_clken), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_done", 32'(done_pulse), 32'h0);
      reset = 1'b0;
      @(negedge clk);
      check("clken_on", 32'(bus.ram_clken), 32'h1);
      check("idle_no_cs", 32'(bus.ram_chipselect), 32'h0);

      enable = 1'b1;
      idle_mon = 1'b1;
      p0 = polls; w0 = writes; o0 = other_rd;
      repeat (200) @(negedge clk);
      idle_mon = 1'b0;
      check("idle_writes", 32'(writes - w0), 32'h0);
      check("idle_other_rd", 32'(other_rd - o0), 32'h0);
      check("idle_busy", 32'(busy_hi), 32'h0);
      check("idle_spacing", 32'(spacing_bad), 32'h0);
      check("idle_polls", 32'(polls - p0 >= 200 / SPACING - 1), 32'h1);

      run_op(32'd3, 32'd5, 1'b0);
      check("vec_3x5", mem[3], 32'h0000000F);
      check("vec_3x5_ctrl", mem[2], 32'h00000104);
      run_op(32'h0000FFFF, 32'h0000FFFF, 1'b0);
`ifdef RAM_MULT_SIGNED_EN
      check("vec_ffff_sq", mem[3], 32'h00000001);
`else
      check("vec_ffff_sq", mem[3], 32'hFFFE0001);
`endif
      run_op(32'hABCDFFFF, 32'h12340002, 1'b0);
`ifdef RAM_MULT_SIGNED_EN
      check("vec_ffff_x2", mem[3], 32'hFFFFFFFE);
`else
      check("vec_ffff_x2", mem[3], 32'h0001FFFE);
`endif
      run_op(32'h00008000, 32'h00008000, 1'b0);
      check("vec_8000_sq", mem[3], 32'h40000000);

      hps_write(2'd3, 32'h5A5AA5A5);
      r0 = rdb_cnt;
      hps_write(2'd0, 32'd11);
      hps_write(2'd1, 32'd13);
      hps_write(2'd2, 32'h1);
      ok = 1'b0;
      for (int i = 0; i < 400 && !ok; i++) begin
         @(negedge clk);
         if (rdb_cnt != r0) ok = 1'b1;
      end
      check("rdb_seen", 32'(ok), 32'h1);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      #1;
      check("midrst_cs", 32'(bus.ram_chipselect), 32'h0);
      check("midrst_busy", 32'(busy), 32'h0);
      repeat (3) @(negedge clk);
      check("midrst_word3", mem[3], 32'h5A5AA5A5);
      reset = 1'b0;
      seq_m = 8'h0;
      run_op(32'd7, 32'd9, 1'b0);
      check("midrst_seq", mem[2], 32'h00000104);

      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      seq_m = 8'h0;
      for (int i = 0; i < 257; i++) begin
         a = $urandom;
         b = $urandom;
         if (i % 17 == 3) a[15:0] = 16'h0;
         if (i % 19 == 5) b[15:0] = 16'hFFFF;
         run_op(a, b, 1'b0);
      end
      a = mem[2];
      check("seq_wrap", 32'(a[15:8]), 32'h01);

      run_op($urandom, $urandom, 1'b1);
      check("drop_enable", 32'(enable), 32'h0);
      p0 = polls;
      repeat (100) @(negedge clk);
      check("no_poll_after_drop", 32'(polls - p0), 32'h0);
      check("idle_busy_after_drop", 32'(busy), 32'h0);
      check("bus_rules", 32'(bus_bad), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
